// File: rtl/dance_pkg.sv
// Shared state encoding and constants for the dance game sequencer.
package dance_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PLAY  = 2'b01,
        DRAIN = 2'b10,
        DONE  = 2'b11
    } game_state_t;

    localparam logic signed [3:0] plus_one = 4'sd1;
    localparam logic signed [3:0] plus_two = 4'sd2;
    localparam logic signed [3:0] neg_two  = -4'sd2;

    localparam logic [7:0] lfsr_seed = 8'hA5;
    localparam int         top_w     = 3;

    // 8-bit Fibonacci LFSR, taps 8,6,5,4
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

endpackage

// File: rtl/dance_top_finder.sv
// Per-lane priority encoder: 0 when dark, else index of highest lit cell + 1.
module dance_top_finder
    import dance_pkg::*;
#(
    parameter int CELLS = 5
)(
    input  logic [CELLS-1:0] lit,
    output logic [top_w-1:0] pos
);

    always_comb begin
        pos = '0;
        for (int c = 0; c < CELLS; c++)
            if (lit[c])
                pos = top_w'(c + 1);
    end

endmodule

// File: rtl/dance_game_ctrl.sv
// Beat generator, note spawner, score accumulator and round FSM.
// Optional miss penalty enabled by defining DANCE_MISS_PENALTY_EN.
module dance_game_ctrl
    import dance_pkg::*;
#(
    parameter int NUM_LANES  = 4,
    parameter int CELLS      = 5,
    parameter int TICK_DIV   = 12500000,
    parameter int GAME_BEATS = 64,
    parameter int SCORE_W    = 8
)(
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic                         Start,
    input  logic [NUM_LANES*CELLS-1:0]   lane_lit,
    input  logic [NUM_LANES*4-1:0]       lane_pt,
    output logic                         step,
    output logic [NUM_LANES-1:0]         spawn,
    output logic [NUM_LANES*top_w-1:0]   top_pos,
    output logic [SCORE_W-1:0]           score,
    output logic [7:0]                   beat_cnt,
    output logic                         game_over
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int AW = SCORE_W + 4;
    localparam logic [TW-1:0] tick_last = TW'(TICK_DIV - 1);

    game_state_t state;
    logic [TW-1:0] tick;
    logic [7:0] lfsr;
    logic [7:0] beat_inc;
    logic [2:0] drain_cnt;
    logic start_q;
    logic start_rise;
    logic in_round;

    logic signed [AW-1:0] delta;
    logic signed [AW-1:0] sum_full;
    logic [SCORE_W-1:0] score_nx;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        dance_top_finder #(
            .CELLS(CELLS)
        ) u_top (
            .lit(lane_lit[l*CELLS +: CELLS]),
            .pos(top_pos[l*top_w +: top_w])
        );
    end

    assign start_rise = Start & ~start_q;
    assign in_round   = (state == PLAY) || (state == DRAIN);
    assign step       = in_round && (tick == tick_last);

    assign spawn = (state == PLAY && step && lfsr[7:6] != 2'b00)
                 ? NUM_LANES'(1) << lfsr[1:0]
                 : '0;

    assign beat_inc = (beat_cnt == 8'hFF) ? beat_cnt : beat_cnt + 8'd1;

    // Score math is done wide and signed, then clamped to [0, 2^SCORE_W-1]
    always_comb begin
        delta = '0;
        for (int l = 0; l < NUM_LANES; l++)
            delta = delta + AW'($signed(lane_pt[l*4 +: 4]));
`ifdef DANCE_MISS_PENALTY_EN
        if (step)
            for (int l = 0; l < NUM_LANES; l++)
                if (lane_lit[l*CELLS + CELLS - 1])
                    delta = delta + AW'(neg_two);
`endif
        sum_full = $signed({4'b0000, score}) + delta;
        if (sum_full < 0)
            score_nx = '0;
        else if (sum_full > $signed({4'b0000, {SCORE_W{1'b1}}}))
            score_nx = '1;
        else
            score_nx = sum_full[SCORE_W-1:0];
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= IDLE;
            tick      <= '0;
            lfsr      <= lfsr_seed;
            start_q   <= 1'b0;
            score     <= '0;
            beat_cnt  <= '0;
            drain_cnt <= '0;
            game_over <= 1'b0;
        end else begin
            start_q <= Start;
            unique case (state)
                IDLE, DONE: begin
                    tick <= '0;
                    if (start_rise) begin
                        state     <= PLAY;
                        score     <= '0;
                        beat_cnt  <= '0;
                        drain_cnt <= '0;
                        game_over <= 1'b0;
                    end
                end
                PLAY: begin
                    score <= score_nx;
                    tick  <= step ? '0 : tick + TW'(1);
                    if (step) begin
                        lfsr     <= lfsr_next(lfsr);
                        beat_cnt <= beat_inc;
                        if (beat_inc == 8'(GAME_BEATS)) begin
                            state     <= DRAIN;
                            drain_cnt <= '0;
                        end
                    end
                end
                DRAIN: begin
                    score <= score_nx;
                    tick  <= step ? '0 : tick + TW'(1);
                    if (step) begin
                        drain_cnt <= drain_cnt + 3'd1;
                        if (drain_cnt == 3'(CELLS - 1)) begin
                            state     <= DONE;
                            game_over <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dance_game_ctrl.sv
// Self-checking bench for dance_game_ctrl: behavioural model plus directed literals.
module tb_dance_game_ctrl;
    import dance_pkg::*;

    localparam int NL = 4;
    localparam int NC = 5;
    localparam int TD = 4;
    localparam int GB = 3;
    localparam int SW = 8;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    logic Start = 1'b0;
    logic [NL*NC-1:0] lane_lit = '0;
    logic [NL*4-1:0] lane_pt = '0;
    logic step;
    logic [NL-1:0] spawn;
    logic [NL*3-1:0] top_pos;
    logic [SW-1:0] score;
    logic [7:0] beat_cnt;
    logic game_over;

    int n_tests = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    bit m_active = 1'b0;
    bit m_done = 1'b0;
    bit m_prev_start = 1'b0;
    int m_cyc = 0;
    int m_steps = 0;
    int m_score = 0;
    logic [7:0] m_lfsr = 8'hA5;

    dance_game_ctrl #(
        .NUM_LANES(NL),
        .CELLS(NC),
        .TICK_DIV(TD),
        .GAME_BEATS(GB),
        .SCORE_W(SW)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .Start(Start),
        .lane_lit(lane_lit),
        .lane_pt(lane_pt),
        .step(step),
        .spawn(spawn),
        .top_pos(top_pos),
        .score(score),
        .beat_cnt(beat_cnt),
        .game_over(game_over)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int exp_top(input logic [NL*NC-1:0] lit, input int l);
        for (int c = NC - 1; c >= 0; c--)
            if (lit[l*NC + c])
                return c + 1;
        return 0;
    endfunction

    // Compare now, then advance the model to what the next edge produces
    always @(negedge Clock) begin
        logic [NL-1:0] e_spawn;
        bit e_step;
        int e_beat;
        int delta;
        e_step  = m_active && (m_cyc % TD == TD - 1);
        e_spawn = '0;
        if (e_step && m_steps < GB && m_lfsr[7:6] != 2'b00)
            e_spawn[m_lfsr[1:0]] = 1'b1;
        e_beat = (m_steps < GB) ? m_steps : GB;
        if (chk_en) begin
            check("step", step, e_step);
            check("spawn", spawn, e_spawn);
            for (int l = 0; l < NL; l++)
                check("top_pos", top_pos[l*3 +: 3], exp_top(lane_lit, l));
            check("score", score, m_score);
            check("beat_cnt", beat_cnt, e_beat);
            check("game_over", game_over, m_done);
        end
        if (Reset) begin
            m_active = 0; m_done = 0; m_prev_start = 0;
            m_cyc = 0; m_steps = 0; m_score = 0; m_lfsr = 8'hA5;
        end else begin
            if (m_active) begin
                delta = 0;
                for (int l = 0; l < NL; l++)
                    delta += $signed(lane_pt[l*4 +: 4]);
`ifdef DANCE_MISS_PENALTY_EN
                if (e_step)
                    for (int l = 0; l < NL; l++)
                        if (lane_lit[l*NC + NC - 1])
                            delta -= 2;
`endif
                m_score += delta;
                if (m_score < 0) m_score = 0;
                if (m_score > 2**SW - 1) m_score = 2**SW - 1;
                if (e_step) begin
                    if (m_steps < GB)
                        m_lfsr = {m_lfsr[6:0],
                                  m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
                    m_steps++;
                    if (m_steps == GB + NC) begin
                        m_active = 0;
                        m_done = 1;
                    end
                end
                m_cyc++;
            end else if (Start && !m_prev_start) begin
                m_active = 1; m_done = 0;
                m_cyc = 0; m_steps = 0; m_score = 0;
            end
            m_prev_start = Start;
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic next_step(output int waited);
        waited = 0;
        do begin
            tick();
            waited++;
        end while (!step && waited < 20);
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (!game_over && k < 100) begin
            tick();
            k++;
        end
        check("round_end", game_over, 1);
    endtask

    task automatic begin_round();
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    initial begin
        int n;
        tick();
        chk_en = 1'b1;
        tick();
        Reset = 1'b0;
        repeat (20) tick();
        check("idle_score", score, 0);
        check("idle_over", game_over, 0);

        // First round from seed 8'hA5: spawns 0010, 0100, 0010
        begin_round();
        n = 1;
        while (!step && n < 20) begin
            tick();
            n++;
        end
        check("first_step_lat", n, 4);
        check("spawn0", spawn, 4'b0010);
        next_step(n);
        check("step_period", n, TD);
        check("spawn1", spawn, 4'b0100);
        next_step(n);
        check("spawn2", spawn, 4'b0010);
        wait_done();
        check("done_beats", beat_cnt, 3);

        lane_lit = '0;
        lane_lit[4:0] = 5'b00101;
        lane_lit[9:5] = 5'b10000;
        #1;
        check("top_lane0", top_pos[2:0], 3);
        check("top_lane1", top_pos[5:3], 5);
        check("top_lane3", top_pos[11:9], 0);
        lane_lit = '0;

        begin_round();
        check("score_start", score, 0);
        lane_pt = {4'h0, 4'h0, 4'(plus_two), 4'h0};
        tick();
        check("score_a", score, 2);
        lane_pt = {4'h0, 4'(neg_two), 4'h0, 4'h0};
        tick();
        check("score_b", score, 0);
        tick();
        check("score_c", score, 0);
        tick();
        check("score_d", score, 0);
        lane_pt = '0;
        wait_done();

        // Start held high through the round must not retrigger
        Start = 1'b1;
        tick();
        lane_pt = {4{4'(plus_two)}};
        repeat (40) tick();
        check("score_sat", score, 255);
        check("no_retrigger", game_over, 1);
        Start = 1'b0;
        lane_pt = '0;
        tick();

        begin_round();
        lane_pt = {3'b000, 13'(plus_one)};
        repeat (6) tick();
        check("pre_reset_score", score, 6);
        lane_pt = '0;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("rst_score", score, 0);
        check("rst_beats", beat_cnt, 0);
        check("rst_over", game_over, 0);
        begin_round();
        next_step(n);
        check("reseed_spawn", spawn, 4'b0010);
        wait_done();

`ifdef DANCE_MISS_PENALTY_EN
        begin_round();
        lane_pt = 16'h0005;
        tick();
        lane_pt = '0;
        check("miss_pre", score, 5);
        tick();
        tick();
        check("miss_step", step, 1);
        lane_lit[NC-1] = 1'b1;
        tick();
        lane_lit = '0;
        check("miss_score", score, 3);
        wait_done();
`endif

        repeat (800) begin
            lane_pt  = 16'($urandom);
            lane_lit = 20'($urandom);
            if ($urandom_range(0, 7) == 0)
                Start = ~Start;
            Reset = ($urandom_range(0, 299) == 0);
            tick();
        end
        Reset = 1'b0;
        lane_pt = '0;
        lane_lit = '0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
